// File: rtl/wb_memory_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_memory_pipe_if
// Description : Wishbone (pipelined mode) request/response bundle for
//               wb_memory_pipe. The master drives the block select, cycle,
//               strobe, write enable, byte selects, address and write data.
//               The slave returns stall, ack and read data.
//   Signals   : i_enable   block select (low blocks new requests)
//               i_wb_cyc   bus cycle active (low aborts in-flight requests)
//               i_wb_stb   request strobe
//               i_we       1 = write, 0 = read
//               i_wb_sel   byte-lane enables, DW/8 bits
//               i_addr     word address, AW bits
//               i_data     write data, DW bits
//               o_wb_stall request not accepted this cycle
//               o_wb_ack   one-cycle completion pulse per accepted request
//               o_data     read data, DW bits, zero unless acking a read
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_memory_pipe_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic                i_enable;
    logic                i_wb_cyc;
    logic                i_wb_stb;
    logic                i_we;
    logic [DW/8-1:0]     i_wb_sel;
    logic [AW-1:0]       i_addr;
    logic [DW-1:0]       i_data;
    logic                o_wb_stall;
    logic                o_wb_ack;
    logic [DW-1:0]       o_data;

    modport master (
        output i_enable, i_wb_cyc, i_wb_stb, i_we, i_wb_sel, i_addr, i_data,
        input  o_wb_stall, o_wb_ack, o_data
    );

    modport slave (
        input  i_enable, i_wb_cyc, i_wb_stb, i_we, i_wb_sel, i_addr, i_data,
        output o_wb_stall, o_wb_ack, o_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_memory_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wb_memory_pipe
// Description : Single-port Wishbone (pipelined) block RAM with per-byte
//               write enables, configurable read/ack latency (1-4 cycles),
//               one request per cycle and cycle-abort support.
// Parameters  : ROMFILE  hex preload file, "" for none
//               SIZE     depth in words (>= 2, any value)
//               DW       data width, multiple of 8, 8..64
//               LATENCY  acceptance edge to ack, 1..4
// Ports       : clk        rising-edge clock
//               i_reset_n  asynchronous active-low reset of the control path
//               bus        wb_memory_pipe_if slave modport
// Revision    : 1.0 - initial release
// ============================================================================
module wb_memory_pipe #(
    parameter     ROMFILE = "",
    parameter int SIZE    = 64,
    parameter int DW      = 32,
    parameter int LATENCY = 1
) (
    input  wire logic          clk,
    input  wire logic          i_reset_n,
    wb_memory_pipe_if.slave    bus
);

    localparam int           AW     = $clog2(SIZE);
    localparam int           NB     = DW / 8;
    localparam logic [AW:0]  SIZE_W = (AW + 1)'(SIZE);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("wb_memory_pipe: LATENCY must be 1..4");
    end
    if (SIZE < 2) begin : g_bad_size
        $error("wb_memory_pipe: SIZE must be >= 2");
    end
    if ((DW % 8) != 0 || DW < 8 || DW > 64) begin : g_bad_dw
        $error("wb_memory_pipe: DW must be a multiple of 8 in 8..64");
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DW-1:0] ram [0:SIZE-1];

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic          acc;
    logic          in_range;
    logic          wr_en;
    logic [DW-1:0] rd_word;

    // The only stall source is the block select, so stall is a plain inverter.
    assign bus.o_wb_stall = !bus.i_enable;
    assign acc            = bus.i_wb_cyc & bus.i_wb_stb & bus.i_enable;
    // SIZE need not be a power of two, so compare with one spare bit.
    assign in_range       = ({1'b0, bus.i_addr} < SIZE_W);
    assign wr_en          = acc & bus.i_we & in_range;

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = ram[bus.i_addr];
        end
    end

    // Array write: only selected lanes change; out-of-range writes vanish.
    // The array has no reset so contents survive a control-path reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.i_wb_sel[b]) begin
                    ram[bus.i_addr][8*b +: 8] <= bus.i_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response pipeline
    //
    // Stage 0 is loaded at the acceptance edge; the last stage drives the bus
    // directly. The data word doubles as the is-read tag: it is loaded only
    // for accepted reads and is zero for writes and empty slots, so o_data is
    // zero whenever ack is low or the ack belongs to a write.
    // ------------------------------------------------------------------------
    logic [LATENCY-1:0] valid;
    logic [DW-1:0]      pipe_data [LATENCY];

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else if (!bus.i_wb_cyc) begin
            // Abort: every in-flight request is forgotten on this edge.
            valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            valid[0]     <= acc;
            pipe_data[0] <= (acc && !bus.i_we) ? rd_word : '0;
            for (int i = 1; i < LATENCY; i++) begin
                valid[i]     <= valid[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign bus.o_wb_ack = valid[LATENCY-1];
    assign bus.o_data   = pipe_data[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_wb_memory_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_memory_pipe
// Description : Self-checking bench for wb_memory_pipe (SIZE=48, DW=32,
//               LATENCY=3). Expected responses are queued when a request is
//               accepted and compared, including the ack cycle, when acks
//               appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_memory_pipe;

    localparam int SIZE = 48;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int AW   = $clog2(SIZE);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_memory_pipe_if #(.DW(DW), .AW(AW)) bus ();

    wb_memory_pipe #(
        .ROMFILE (""),
        .SIZE    (SIZE),
        .DW      (DW),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            edge_no;
        string         tag;
    } exp_t;

    exp_t          sb [$];
    exp_t          mon_e;
    logic [DW-1:0] model [SIZE];
    int            edge_no = 0;
    int            checks  = 0;
    int            errors  = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one request for one clock; if it is accepted, update the memory
    // model and queue the expected response with its ack cycle.
    task automatic bus_cycle(input logic cyc, input logic stb, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] sel, input string tag);
        exp_t e;
        bus.i_wb_cyc = cyc;
        bus.i_wb_stb = stb;
        bus.i_we     = we;
        bus.i_addr   = addr;
        bus.i_data   = data;
        bus.i_wb_sel = sel;
        @(posedge clk);
        #1;
        if (!cyc) begin
            sb.delete();
        end else if (rst_n && stb && bus.i_enable) begin
            e.edge_no = edge_no + LAT - 1;
            e.tag     = tag;
            e.data    = '0;
            if (we) begin
                if (int'(addr) < SIZE) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) model[addr][8*b +: 8] = data[8*b +: 8];
                    end
                end
            end else if (int'(addr) < SIZE) begin
                e.data = model[addr];
            end
            sb.push_back(e);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] s, input string tag);
        bus_cycle(1'b1, 1'b1, 1'b1, a, d, s, tag);
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        bus_cycle(1'b1, 1'b1, 1'b0, a, '0, 4'h0, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(1'b1, 1'b0, 1'b0, '0, '0, 4'h0, "idle");
    endtask

    // Response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("reset_ack", bus.o_wb_ack, 0);
            check_eq("reset_data", bus.o_data, 0);
        end else if (bus.o_wb_ack) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 64'(sb.size() > 0), 1);
            end else begin
                mon_e = sb.pop_front();
                check_eq({mon_e.tag, "_cycle"}, 64'(edge_no), 64'(mon_e.edge_no));
                check_eq({mon_e.tag, "_data"}, bus.o_data, mon_e.data);
            end
        end else begin
            check_eq("idle_data", bus.o_data, 0);
            if (sb.size() > 0 && sb[0].edge_no <= edge_no) begin
                check_eq({sb[0].tag, "_ack"}, bus.o_wb_ack, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        bus.i_enable = 1'b1;
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_we     = 1'b0;
        bus.i_addr   = '0;
        bus.i_data   = '0;
        bus.i_wb_sel = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill: addr i = i*0x10, plus a marker word at addr 3.
        for (int i = 0; i < 8; i++) wr(AW'(i), DW'(i * 'h10), 4'hF, "fill");
        idle(1);
        wr(6'd3, 32'hDEADBEEF, 4'hF, "wr3");
        rd(6'd3, "rd3");
        idle(4);

        // Byte lanes, then an all-lanes-off write that must still ack.
        wr(6'd5, 32'h11223344, 4'hF, "lane_full");
        wr(6'd5, 32'hAABBCCDD, 4'b0101, "lane_part");
        rd(6'd5, "lane_rd");
        wr(6'd5, 32'hFFFFFFFF, 4'h0, "sel0_wr");
        rd(6'd5, "sel0_rd");
        idle(4);
        check_eq("lane_model", model[5], 32'h11BB33DD);

        // Streaming reads and write-then-immediate-read.
        wr(6'd3, 32'h00000030, 4'hF, "restore3");
        for (int i = 0; i < 8; i++) rd(AW'(i), "stream");
        wr(6'd9, 32'h99999999, 4'hF, "wr9");
        rd(6'd9, "rd9_next");
        idle(4);

        // Address range: last valid word and out-of-range word.
        wr(6'd47, 32'h47474747, 4'hF, "wr47");
        wr(6'd50, 32'h00000055, 4'hF, "wr50");
        rd(6'd47, "rd47");
        rd(6'd50, "rd50");
        idle(4);

        // Abort: two requests in flight, cycle dropped with a strobe pending.
        rd(6'd0, "abort_rd0");
        wr(6'd10, 32'h0000A5A5, 4'hF, "abort_wr10");
        bus_cycle(1'b0, 1'b1, 1'b0, 6'd1, '0, 4'h0, "abort_rd1");
        repeat (5) bus_cycle(1'b0, 1'b0, 1'b0, '0, '0, 4'h0, "abort_idle");
        rd(6'd10, "after_abort_rd10");
        idle(4);

        // Enable/stall: in-flight request drains while new ones are blocked.
        rd(6'd7, "inflight_rd7");
        bus.i_enable = 1'b0;
        #1 check_eq("stall_on", bus.o_wb_stall, 1);
        repeat (4) rd(6'd2, "blocked");
        check_eq("stall_hold", bus.o_wb_stall, 1);
        bus.i_enable = 1'b1;
        #1 check_eq("stall_off", bus.o_wb_stall, 0);
        rd(6'd2, "resume_rd2");
        idle(4);

        // Asynchronous reset in the middle of a burst of acks.
        for (int i = 0; i < 6; i++) rd(AW'(i), "burst");
        bus.i_wb_stb = 1'b0;
        @(negedge clk);
        #1 check_eq("ack_before_reset", bus.o_wb_ack, 1);
        rst_n = 1'b0;
        sb.delete();
        #1 check_eq("async_ack_drop", bus.o_wb_ack, 0);
        check_eq("async_data_drop", bus.o_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        rd(6'd5, "retained5");
        rd(6'd9, "retained9");
        rd(6'd10, "retained10");

        // Drain with a bounded wait.
        for (int n = 0; n < 20 && sb.size() > 0; n++) idle(1);
        check_eq("drain", 64'(sb.size()), 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_memory_pipe.md
# wb_memory_pipe

Parametrised successor to the single-port Wishbone block RAM. It provides configurable data width and depth, per-byte write enables, and a configurable read/ack latency of 1–4 cycles with one request accepted per cycle. It also honours `i_wb_cyc` aborts and has an asynchronous active-low reset on the control path. It sits on the SoC Wishbone (pipelined mode) bus as boot ROM, scratch RAM or framebuffer, with optional `$readmemh` preload.

## Interface
- `ROMFILE`, "", hex preload file; empty string means no preload.
- `SIZE`, 64, depth in words, ≥ 2; need not be a power of two.
- `DW`, 32, data width; multiple of 8, range 8–64.
- `LATENCY`, 1, cycles from acceptance edge to ack; legal values 1–4 (elaboration error otherwise).
- `AW`, `$clog2(SIZE)`, derived word-address width; not overridden.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `i_reset_n`  in  1  asynchronous active-low reset.
- `i_enable`  in  1  block select; low blocks new requests.
- `i_wb_cyc`  in  1  bus cycle active.
- `i_wb_stb`  in  1  request strobe.
- `o_wb_stall`  out  1  request not accepted this cycle.
- `o_wb_ack`  out  1  one-cycle completion pulse per accepted request.
- `i_we`  in  1  1 = write, 0 = read.
- `i_wb_sel`  in  DW/8  byte-lane enables for writes.
- `i_addr`  in  AW  word address.
- `i_data`  in  DW  write data.
- `o_data`  out  DW  read data; valid only while `o_wb_ack` is high for a read.

## Operation
- Accept condition: `acc = i_wb_cyc & i_wb_stb & !o_wb_stall`.
- `o_wb_stall = !i_enable`, combinational; there are no other stall sources.
- Write, on the `acc` edge:
  - for each lane b with `i_wb_sel[b]=1`, `ram[i_addr][8b+7:8b] <= i_data[8b+7:8b]`;
  - lanes with `i_wb_sel[b]=0` are unchanged;
  - `i_wb_sel=0` is a legal no-op write that is still acked.
- Read: the word is sampled from the array on the `acc` edge and carried through `LATENCY-1` further register stages with its valid bit.
- Write-first ordering: the array is updated at the accept edge, so a read accepted the cycle after a write to the same address returns the new data.
- Out-of-range address (`i_addr ≥ SIZE`): the write is dropped, a read returns 0, and the request is still acked.
- Pipeline structure:
  - `LATENCY` valid bits plus a read-data shift register and an is-read tag per stage;
  - the pipeline always advances; `i_enable` low blocks new entries but in-flight requests still drain and ack.
- Abort: `i_wb_cyc=0` at a rising edge clears every in-flight valid bit on that edge.
  - No ack is ever issued for a request accepted before the abort.
  - Writes already committed to the array stay committed.
- `o_data` is 0 whenever `o_wb_ack=0`, and 0 for write acks.
- Reset (`i_reset_n=0`, asynchronous):
  - all valid bits clear; `o_wb_ack=0`, `o_data=0`;
  - array contents are untouched (no clear, no reload);
  - after deassertion, the first request is accepted on the first edge at which `acc` holds.
- Preload: at initialisation, if `ROMFILE` is non-empty, `$readmemh(ROMFILE, ram)`; otherwise contents are undefined.

## Timing
- Request accepted at edge k → `o_wb_ack` high during the cycle after edge k+LATENCY-1.
  - `LATENCY=1`: ack in the cycle right after acceptance, identical to the previous block.
- Throughput is one request per cycle; back-to-back requests give back-to-back acks in issue order.
- Acks are never merged or dropped, except on abort or reset.
- `o_wb_ack` and `o_data` come directly from flops; there is no combinational path from inputs to them.
- The stall path from `i_enable` is combinational.
- Abort and new request on the same edge: with `cyc=0`, `acc` is 0, so nothing is accepted and the pipeline clears.
- Reset asserted mid-burst: acks drop immediately, without waiting for a clock edge.

## Test plan
- Reset/preload: `ROMFILE` word 3 = 0xDEADBEEF, `LATENCY=2`; read addr 3 → ack exactly 2 cycles after acceptance, `o_data=0xDEADBEEF`; `o_wb_ack`/`o_data` are 0 throughout reset.
- Byte lanes: write 0x11223344 to addr 5 with `sel=4'hF`, then 0xAABBCCDD with `sel=4'b0101`, then read → 0x11BB33DD.
- Streaming: `LATENCY=3`, 8 back-to-back reads of addr 0..7 preloaded with i*0x10 → 8 consecutive ack cycles, data 0x00..0x70 in order, and the write-then-immediate-read of the same address returns the new value.
- Abort: `LATENCY=4`; issue 3 reads, drop `i_wb_cyc` 2 cycles after the first acceptance → zero acks. A write issued in the same burst is visible on a later read.
- Enable/stall: hold `i_enable=0` with `stb=1` → `o_wb_stall=1`, no accept, no ack. Requests already in flight before the drop still ack. Raising `i_enable` resumes acceptance the same cycle.
- Range/reset: `SIZE=48`; write 0x55 to addr 50 → acked, and a read of addr 50 returns 0. Assert `i_reset_n` low mid-burst → ack low asynchronously, no stale acks after release, and array data written earlier is retained.
